// File: rtl/axis_packet_fifo_if.sv
// AXI-Stream beat bundle used on both sides of axis_packet_fifo.
// The master drives valid/last/data and the slave drives ready.
interface axis_packet_fifo_if #(
    parameter int AXIS_BYTES = 1
) ();
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic [AXIS_BYTES*8-1:0] tdata;

    modport master (output tvalid, output tlast, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/axis_packet_fifo.sv
// Store-and-forward AXI-Stream FIFO: a packet becomes visible downstream only after its tlast beat is stored.
// Define AXIS_PACKET_FIFO_DROP_EN to drop overflowing packets whole instead of back-pressuring the source.
module axis_packet_fifo #(
    parameter int AXIS_BYTES = 1,
    parameter int DEPTH      = 256
) (
    input  logic                      clk,
    input  logic                      areset,
    axis_packet_fifo_if.slave         axis_i,
    axis_packet_fifo_if.master        axis_o,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      dropped
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int DATA_W = AXIS_BYTES * 8;
    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE    = (ADDR_W + 1)'(1);

    logic [DATA_W:0] mem [DEPTH];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] commit_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            ready_en;
    logic            full;
    logic            in_accept;
    logic            do_write;
    logic            rewind;
    logic            do_load;

    assign occupancy = wr_ptr - rd_ptr;
    assign full      = (occupancy == FULL_LEVEL);
    assign in_accept = axis_i.tvalid && axis_i.tready;

    // Input side stays closed until the first clock edge after reset release.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

`ifdef AXIS_PACKET_FIFO_DROP_EN
    typedef enum logic {ST_PASS, ST_DROP} drop_state_t;

    drop_state_t state;
    drop_state_t state_next;
    logic        drop_pulse_next;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state   <= ST_PASS;
            dropped <= 1'b0;
        end else begin
            state   <= state_next;
            dropped <= drop_pulse_next;
        end
    end

    // A beat hitting a full buffer condemns the rest of its packet through tlast.
    always_comb begin
        state_next = state;
        case (state)
            ST_PASS: if (in_accept && full && !axis_i.tlast) state_next = ST_DROP;
            ST_DROP: if (in_accept && axis_i.tlast)          state_next = ST_PASS;
            default: state_next = ST_PASS;
        endcase
    end

    always_comb begin
        do_write        = in_accept && (state == ST_PASS) && !full;
        rewind          = in_accept && (state == ST_PASS) && full;
        drop_pulse_next = in_accept && axis_i.tlast && ((state == ST_DROP) || full);
    end

    assign axis_i.tready = ready_en;
`else
    assign do_write      = in_accept;
    assign rewind        = 1'b0;
    assign dropped       = 1'b0;
    assign axis_i.tready = ready_en && !full;
`endif

    // Rewinding to commit_ptr discards only the packet in progress; committed data is untouched.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
        end else begin
            if (rewind) begin
                wr_ptr <= commit_ptr;
            end else if (do_write) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_write && axis_i.tlast) begin
                commit_ptr <= wr_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {axis_i.tlast, axis_i.tdata};
        end
    end

    assign do_load = (rd_ptr != commit_ptr) && (!axis_o.tvalid || axis_o.tready);

    // Single output register; a stalled beat holds its data until the handshake.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rd_ptr       <= '0;
            axis_o.tvalid <= 1'b0;
            axis_o.tlast  <= 1'b0;
            axis_o.tdata  <= '0;
        end else if (do_load) begin
            {axis_o.tlast, axis_o.tdata} <= mem[rd_ptr[ADDR_W-1:0]];
            axis_o.tvalid <= 1'b1;
            rd_ptr        <= rd_ptr + PTR_ONE;
        end else if (axis_o.tready) begin
            axis_o.tvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axis_packet_fifo.sv
// Self-checking bench for axis_packet_fifo (DEPTH=8, 1-byte beats): queue-based packet model plus directed scenarios.
// Builds with or without AXIS_PACKET_FIFO_DROP_EN.
module tb_axis_packet_fifo;
    localparam int DEPTH = 8;
    localparam int OW    = $clog2(DEPTH) + 1;
`ifdef AXIS_PACKET_FIFO_DROP_EN
    localparam int MAXLEN = 11;
`else
    localparam int MAXLEN = DEPTH;
`endif

    typedef logic [8:0] beat_t;

    logic          clk = 1'b0;
    logic          areset;
    logic [OW-1:0] occupancy;
    logic          dropped;

    axis_packet_fifo_if #(.AXIS_BYTES(1)) in_if ();
    axis_packet_fifo_if #(.AXIS_BYTES(1)) out_if ();

    axis_packet_fifo #(.AXIS_BYTES(1), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .areset    (areset),
        .axis_i    (in_if),
        .axis_o    (out_if),
        .occupancy (occupancy),
        .dropped   (dropped)
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    drop_seen = 0;
    bit    rand_on = 0;
    beat_t out_log[$];
    int    out_cyc[$];

    // Reference model: committed packets and the packet in progress as plain queues.
    beat_t committed[$];
    beat_t pending[$];
    beat_t m_b;
    logic  m_ov, m_ol, m_dropped, m_drop, m_ready_en;
    logic [7:0] m_od;
    bit    m_acc, m_full, m_load;

    function automatic int m_occ();
        return committed.size() + pending.size();
    endfunction

    function automatic bit m_ready();
`ifdef AXIS_PACKET_FIFO_DROP_EN
        return m_ready_en;
`else
        return m_ready_en && (m_occ() != DEPTH);
`endif
    endfunction

    task automatic m_store();
        pending.push_back({in_if.tlast, in_if.tdata});
        if (in_if.tlast) begin
            while (pending.size() > 0) committed.push_back(pending.pop_front());
        end
    endtask

    always @(posedge clk or posedge areset) begin
        if (areset) begin
            committed.delete();
            pending.delete();
            m_ov = 0; m_ol = 0; m_od = 0; m_dropped = 0; m_drop = 0; m_ready_en = 0;
        end else begin
            cyc++;
            m_full = (m_occ() == DEPTH);
            m_acc  = in_if.tvalid && m_ready();
            m_load = (committed.size() > 0) && (!m_ov || out_if.tready);
            if (m_load) begin
                m_b = committed.pop_front();
                m_ov = 1;
                {m_ol, m_od} = m_b;
            end else if (out_if.tready) begin
                m_ov = 0;
            end
            m_dropped = 0;
            if (m_acc) begin
`ifdef AXIS_PACKET_FIFO_DROP_EN
                if (m_drop) begin
                    if (in_if.tlast) begin m_dropped = 1; m_drop = 0; end
                end else if (m_full) begin
                    pending.delete();
                    if (in_if.tlast) m_dropped = 1;
                    else m_drop = 1;
                end else begin
                    m_store();
                end
`else
                m_store();
`endif
            end
            m_ready_en = 1;
        end
    end

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        check_output("tready", 32'(in_if.tready), 32'(m_ready()));
        check_output("tvalid", 32'(out_if.tvalid), 32'(m_ov));
        if (m_ov) begin
            check_output("tlast", 32'(out_if.tlast), 32'(m_ol));
            check_output("tdata", 32'(out_if.tdata), 32'(m_od));
        end
        check_output("occupancy", 32'(occupancy), 32'(m_occ()));
        check_output("dropped", 32'(dropped), 32'(m_dropped));
    end

    always @(negedge clk) begin
        if (!areset && out_if.tvalid && out_if.tready) begin
            out_log.push_back({out_if.tlast, out_if.tdata});
            out_cyc.push_back(cyc);
        end
        if (!areset && dropped) drop_seen++;
    end

    task automatic apply_stimulus(logic [7:0] d, logic last, int max_wait);
        int  n = 0;
        bit  acc = 0;
        in_if.tvalid = 1; in_if.tdata = d; in_if.tlast = last;
        do begin
            @(negedge clk);
            acc = m_ready();
            @(posedge clk); #1;
            n++;
        end while (!acc && n < max_wait);
        in_if.tvalid = 0;
        if (!acc) begin
            tests++; fails++;
            $display("[TB] FAIL send_timeout: beat 0x%0h not accepted after %0d cycles", d, n);
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int base, dbase;

    initial begin
        areset = 1; in_if.tvalid = 0; in_if.tlast = 0; in_if.tdata = 0; out_if.tready = 0;
        idle(3);
        check_output("rst_tready", 32'(in_if.tready), 0);
        check_output("rst_tvalid", 32'(out_if.tvalid), 0);
        check_output("rst_occ", 32'(occupancy), 0);
        areset = 0;
        idle(1);
        check_output("tready_after_rst", 32'(in_if.tready), 1);

        // 3-beat packet: nothing shown until the tlast edge, then one beat per cycle.
        out_if.tready = 1;
        base = out_log.size();
        apply_stimulus(8'h11, 0, 20);
        apply_stimulus(8'h22, 0, 20);
        apply_stimulus(8'h33, 1, 20);
        check_output("latency_e0_tvalid", 32'(out_if.tvalid), 0);
        idle(1);
        check_output("latency_e1_tvalid", 32'(out_if.tvalid), 1);
        check_output("latency_e1_tdata", 32'(out_if.tdata), 32'h11);
        idle(5);
        check_output("pkt3_count", 32'(out_log.size() - base), 3);
        check_output("pkt3_b0", 32'(out_log[base]),     32'h011);
        check_output("pkt3_b1", 32'(out_log[base + 1]), 32'h022);
        check_output("pkt3_b2", 32'(out_log[base + 2]), 32'h133);

        // 20 back-to-back single-beat packets with no output gaps.
        base = out_log.size();
        for (int i = 0; i < 20; i++) apply_stimulus(8'(8'h40 + i), 1, 20);
        idle(5);
        check_output("b2b_count", 32'(out_log.size() - base), 20);
        for (int i = 0; i < 20; i++) check_output("b2b_data", 32'(out_log[base + i]), 32'(9'h140 + i));
        check_output("b2b_gapless", 32'(out_cyc[base + 19] - out_cyc[base]), 19);

        // Downstream stalled: 8-beat packet plus one beat of the next packet.
        out_if.tready = 0;
        for (int i = 0; i < 8; i++) apply_stimulus(8'(8'h80 + i), i == 7, 20);
        idle(1);
        apply_stimulus(8'h90, 0, 20);
        check_output("stall_occ", 32'(occupancy), 8);
        check_output("stall_tdata", 32'(out_if.tdata), 32'h80);
`ifndef AXIS_PACKET_FIFO_DROP_EN
        check_output("stall_tready", 32'(in_if.tready), 0);
`endif

        // Asynchronous reset empties the output register immediately.
        areset = 1; #1;
        check_output("async_rst_tvalid", 32'(out_if.tvalid), 0);
        check_output("async_rst_occ", 32'(occupancy), 0);
        idle(2);
        areset = 0;
        idle(1);

        // Reset after 2 of 4 beats, then a clean 2-beat packet.
        out_if.tready = 1;
        apply_stimulus(8'hA0, 0, 20);
        apply_stimulus(8'hA1, 0, 20);
        #2 areset = 1; #1;
        check_output("midpkt_rst_tvalid", 32'(out_if.tvalid), 0);
        check_output("midpkt_rst_occ", 32'(occupancy), 0);
        idle(2);
        areset = 0;
        idle(1);
        base = out_log.size();
        apply_stimulus(8'hB0, 0, 20);
        apply_stimulus(8'hB1, 1, 20);
        idle(5);
        check_output("post_rst_count", 32'(out_log.size() - base), 2);
        check_output("post_rst_b0", 32'(out_log[base]),     32'h0B0);
        check_output("post_rst_b1", 32'(out_log[base + 1]), 32'h1B1);

        // Committed 4-beat packet held by a stalled sink, then a 6-beat packet that overflows.
        out_if.tready = 0;
        base = out_log.size();
        dbase = drop_seen;
        for (int i = 0; i < 4; i++) apply_stimulus(8'(8'hC0 + i), i == 3, 20);
        fork
            begin
                for (int i = 0; i < 6; i++) apply_stimulus(8'(8'hD0 + i), i == 5, 60);
            end
            begin
                idle(30);
                out_if.tready = 1;
            end
        join
        idle(20);
        for (int i = 0; i < 4; i++) check_output("ovf_c", 32'(out_log[base + i]), 32'((i == 3 ? 9'h100 : 9'h000) + 9'h0C0 + i));
`ifdef AXIS_PACKET_FIFO_DROP_EN
        check_output("ovf_count", 32'(out_log.size() - base), 4);
        check_output("ovf_drops", 32'(drop_seen - dbase), 1);
`else
        check_output("ovf_count", 32'(out_log.size() - base), 10);
        for (int i = 0; i < 6; i++) check_output("ovf_d", 32'(out_log[base + 4 + i]), 32'((i == 5 ? 9'h100 : 9'h000) + 9'h0D0 + i));
        check_output("ovf_drops", 32'(drop_seen - dbase), 0);
`endif
        check_output("ovf_occ", 32'(occupancy), 0);

        // Random packets, gaps and sink back-pressure against the model.
        rand_on = 1;
        fork
            begin
                for (int p = 0; p < 40; p++) begin
                    int len;
                    len = $urandom_range(1, MAXLEN);
                    for (int b = 0; b < len; b++) begin
                        if ($urandom_range(0, 3) == 0) idle(1);
                        apply_stimulus(8'($urandom_range(0, 255)), b == len - 1, 200);
                    end
                end
                rand_on = 0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk); #1;
                    out_if.tready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_if.tready = 1;
        idle(30);
        check_output("final_occ", 32'(occupancy), 0);
        check_output("final_tvalid", 32'(out_if.tvalid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
